// File: rtl/compress_pipe_slice_pkg.sv
// Shared definitions for the compress pipeline slice: default field widths,
// slice occupancy encodings and a payload width helper.
package compress_pipe_slice_pkg;

    localparam int DEF_NUM_WEN  = 8;
    localparam int DEF_DATA_W   = 24;
    localparam int DEF_WEIGHT_W = 3;
    localparam int DEF_STATE_W  = 2;
    localparam int DEF_ADDR_W   = 20;

    // Occupancy of the slice: nothing held, main register only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } slice_state_t;

    // Packed payload width: wen lanes + data_en + ram1 + weight + state + ram2_we + ram2_a.
    function automatic int payload_width(input int nw, input int dw, input int ww,
                                         input int sw, input int aw);
        return nw + 1 + dw + ww + sw + 1 + aw;
    endfunction

endpackage

// File: rtl/compress_pipe_slice_skid_reg.sv
// Two-entry valid/ready register slice for a packed W-bit payload.
// in_ready is a registered copy of "skid empty", so it never follows out_ready
// combinationally. Flush drops held beats; reset additionally clears the data.
module compress_pipe_slice_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    import compress_pipe_slice_pkg::*;

    slice_state_t r_state;
    logic         r_out_valid;
    logic         r_in_ready;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;

    logic w_accept;
    logic w_pop;

    assign w_accept  = in_valid & r_in_ready;
    assign w_pop     = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    // Occupancy FSM with registered handshake outputs; reset beats flush beats transfers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (w_accept && w_pop) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new beat and stop upstream.
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (w_pop) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no accept can coincide with the pop.
                    if (w_pop) begin
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_MAIN;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/compress_pipe_slice.sv
// Handshaked register slice between codeword search and the RAM2 write port.
// Packs the payload fields, runs them through the skid slice and gates every
// write strobe with out_valid so bubbles never write memory.
module compress_pipe_slice #(
    parameter int NUM_WEN  = compress_pipe_slice_pkg::DEF_NUM_WEN,
    parameter int DATA_W   = compress_pipe_slice_pkg::DEF_DATA_W,
    parameter int WEIGHT_W = compress_pipe_slice_pkg::DEF_WEIGHT_W,
    parameter int STATE_W  = compress_pipe_slice_pkg::DEF_STATE_W,
    parameter int ADDR_W   = compress_pipe_slice_pkg::DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_WEN-1:0]  in_wen,
    input  logic                in_data_en,
    input  logic [DATA_W-1:0]   in_ram1_q,
    input  logic [WEIGHT_W-1:0] in_weight,
    input  logic [STATE_W-1:0]  in_state,
    input  logic                in_ram2_we,
    input  logic [ADDR_W-1:0]   in_ram2_a,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_WEN-1:0]  out_wen,
    output logic                out_data_en,
    output logic [DATA_W-1:0]   out_ram1_q,
    output logic [WEIGHT_W-1:0] out_weight,
    output logic [STATE_W-1:0]  out_state,
    output logic                out_ram2_we,
    output logic [ADDR_W-1:0]   out_ram2_a
);
    import compress_pipe_slice_pkg::*;

    localparam int PAYLOAD_W = payload_width(NUM_WEN, DATA_W, WEIGHT_W, STATE_W, ADDR_W);

    // Field LSB offsets, packed MSB..LSB as wen, data_en, ram1, weight, state, ram2_we, ram2_a.
    localparam int OFF_A      = 0;
    localparam int OFF_WE     = OFF_A + ADDR_W;
    localparam int OFF_STATE  = OFF_WE + 1;
    localparam int OFF_WEIGHT = OFF_STATE + STATE_W;
    localparam int OFF_RAM1   = OFF_WEIGHT + WEIGHT_W;
    localparam int OFF_DEN    = OFF_RAM1 + DATA_W;
    localparam int OFF_WEN    = OFF_DEN + 1;

    logic [PAYLOAD_W-1:0] w_in_payload;
    logic [PAYLOAD_W-1:0] w_main;
    logic                 w_valid;

    assign w_in_payload = {in_wen, in_data_en, in_ram1_q, in_weight, in_state,
                           in_ram2_we, in_ram2_a};

    compress_pipe_slice_skid_reg #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (w_valid),
        .out_ready (out_ready),
        .out_data  (w_main)
    );

    assign out_valid = w_valid;

    // Non-strobe fields pass straight through and keep their last value in bubbles.
    assign out_ram1_q = w_main[OFF_RAM1 +: DATA_W];
    assign out_weight = w_main[OFF_WEIGHT +: WEIGHT_W];
    assign out_state  = w_main[OFF_STATE +: STATE_W];
    assign out_ram2_a = w_main[OFF_A +: ADDR_W];

    // Strobes are qualified by out_valid so a held stale beat cannot write.
    assign out_data_en = w_main[OFF_DEN] & w_valid;
    assign out_ram2_we = w_main[OFF_WE] & w_valid;

    generate
        for (genvar gi = 0; gi < NUM_WEN; gi++) begin : g_wen_gate
            assign out_wen[gi] = w_main[OFF_WEN + gi] & w_valid;
        end
    endgenerate

endmodule

// File: tb/tb_compress_pipe_slice.sv
// Scoreboard bench for compress_pipe_slice: default-width instance plus a
// NUM_WEN=4 / ADDR_W=12 instance driven by the same stimulus.
module tb_compress_pipe_slice;

    typedef struct packed {
        logic [7:0]  wen;
        logic        data_en;
        logic [23:0] ram1;
        logic [2:0]  weight;
        logic [1:0]  state;
        logic        we;
        logic [19:0] a;
    } beat_t;

    typedef struct {
        beat_t b;
        int    acc;
        bit    lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_wen = '0;
    logic        in_data_en = 1'b0;
    logic [23:0] in_ram1_q = '0;
    logic [2:0]  in_weight = '0;
    logic [1:0]  in_state = '0;
    logic        in_ram2_we = 1'b0;
    logic [19:0] in_ram2_a = '0;

    logic        in_ready, out_valid, out_data_en, out_ram2_we;
    logic [7:0]  out_wen;
    logic [23:0] out_ram1_q;
    logic [2:0]  out_weight;
    logic [1:0]  out_state;
    logic [19:0] out_ram2_a;

    logic        in_ready2, out_valid2, out_data_en2, out_ram2_we2;
    logic [3:0]  out_wen2;
    logic [23:0] out_ram1_q2;
    logic [2:0]  out_weight2;
    logic [1:0]  out_state2;
    logic [11:0] out_ram2_a2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t q1[$];
    exp_t q2[$];

    compress_pipe_slice dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wen(in_wen), .in_data_en(in_data_en), .in_ram1_q(in_ram1_q),
        .in_weight(in_weight), .in_state(in_state), .in_ram2_we(in_ram2_we),
        .in_ram2_a(in_ram2_a),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wen(out_wen), .out_data_en(out_data_en), .out_ram1_q(out_ram1_q),
        .out_weight(out_weight), .out_state(out_state), .out_ram2_we(out_ram2_we),
        .out_ram2_a(out_ram2_a)
    );

    compress_pipe_slice #(.NUM_WEN(4), .ADDR_W(12)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_wen(in_wen[3:0]), .in_data_en(in_data_en), .in_ram1_q(in_ram1_q),
        .in_weight(in_weight), .in_state(in_state), .in_ram2_we(in_ram2_we),
        .in_ram2_a(in_ram2_a[11:0]),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_wen(out_wen2), .out_data_en(out_data_en2), .out_ram1_q(out_ram1_q2),
        .out_weight(out_weight2), .out_state(out_state2), .out_ram2_we(out_ram2_we2),
        .out_ram2_a(out_ram2_a2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int id);
        beat_t b;
        b.wen     = 8'(id * 37 + 1);
        b.data_en = 1'((id % 3) != 0);
        b.ram1    = 24'(id * 24'h010101) ^ 24'hA50000;
        b.weight  = 3'(id);
        b.state   = 2'(id >> 1);
        b.we      = 1'b1;
        b.a       = 20'(id);
        return b;
    endfunction

    // Offer one beat until accepted; the expected entry is queued once acceptance is certain.
    task automatic send(input beat_t b, input bit push, input bit lat);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        {in_wen, in_data_en, in_ram1_q, in_weight, in_state, in_ram2_we, in_ram2_a} = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) begin
                    e.b = b; e.acc = cyc + 1; e.lat = lat;
                    q1.push_back(e);
                    q2.push_back(e);
                end
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout act=in_ready_low exp=accept a=%h", b.a);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Monitor: pop expected beats whenever a DUT transfer is about to happen.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut1_unexpected_beat act=a_%h exp=none", out_ram2_a);
            end else begin
                e = q1.pop_front();
                chk("dut1_payload",
                    64'({out_wen, out_data_en, out_ram1_q, out_weight, out_state,
                         out_ram2_we, out_ram2_a}), 64'(e.b));
                if (e.lat) chk("dut1_latency", 64'(cyc), 64'(e.acc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_valid2 === 1'b1 && out_ready === 1'b1) begin
            if (q2.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut2_unexpected_beat act=a_%h exp=none", out_ram2_a2);
            end else begin
                e = q2.pop_front();
                chk("dut2_payload",
                    64'({out_wen2, out_data_en2, out_ram1_q2, out_weight2, out_state2,
                         out_ram2_we2, out_ram2_a2}),
                    64'({e.b.wen[3:0], e.b.data_en, e.b.ram1, e.b.weight, e.b.state,
                         e.b.we, e.b.a[11:0]}));
                if (e.lat) chk("dut2_latency", 64'(cyc), 64'(e.acc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t b;

        // 1: reset held with a beat offered
        rst = 1'b0;
        in_valid = 1'b1;
        {in_wen, in_data_en, in_ram1_q, in_weight, in_state, in_ram2_we, in_ram2_a} = mk(7);
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_payload", 64'({out_wen, out_data_en, out_ram1_q, out_weight,
                                    out_state, out_ram2_we, out_ram2_a}), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;

        // 2: 16-beat stream at full rate
        for (int i = 0; i < 16; i++) send(mk(i), 1'b1, 1'b1);
        idle(3);

        // 3: backpressure mid-stream
        out_ready = 1'b0;
        send(mk(20), 1'b1, 1'b0);
        send(mk(21), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid_held", 64'(out_valid), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(4);

        // 4: bubble gating after a full-strobe beat
        b = mk(30);
        b.wen = 8'hFF; b.we = 1'b1; b.data_en = 1'b1;
        send(b, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bub_out_valid", 64'(out_valid), 64'd0);
        chk("bub_out_wen", 64'(out_wen), 64'd0);
        chk("bub_out_ram2_we", 64'(out_ram2_we), 64'd0);
        chk("bub_out_data_en", 64'(out_data_en), 64'd0);
        chk("bub_ram1_hold", 64'(out_ram1_q), 64'(b.ram1));
        chk("bub_addr_hold", 64'(out_ram2_a), 64'(b.a));

        // 5: flush while FULL with a beat offered
        out_ready = 1'b0;
        send(mk(40), 1'b0, 1'b0);
        send(mk(41), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        {in_wen, in_data_en, in_ram1_q, in_weight, in_state, in_ram2_we, in_ram2_a} = mk(42);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("flush_stays_empty", 64'(out_valid), 64'd0);

        // 6: reset while FULL, then resume with beat 0x5A
        out_ready = 1'b0;
        send(mk(50), 1'b0, 1'b0);
        send(mk(51), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_payload", 64'({out_wen, out_data_en, out_ram1_q, out_weight,
                                   out_state, out_ram2_we, out_ram2_a}), 64'd0);
        out_ready = 1'b1;
        b = mk(3);
        b.a = 20'h5A; b.ram1 = 24'h5A;
        send(b, 1'b1, 1'b1);
        idle(5);

        @(negedge clk);
        chk("dut1_queue_drained", 64'(q1.size()), 64'd0);
        chk("dut2_queue_drained", 64'(q2.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
